// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, requests to send, shifts one command
// byte out on device clock falls and checks the device ACK, with a bus-activity timeout.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 840,
  parameter int TIMEOUT_CYCLES = 105000,
  parameter int FILTER_LEN     = 4
) (
  input  logic       clk7,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_din_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       rx_inhibit,
  output logic       tx_done,
  output logic       tx_error
);

  // state     | meaning
  // IDLE      | lines released, ready for a command byte
  // INHIBIT   | host holds clock low
  // REQ       | clock and data low (start bit), one cycle
  // BITS      | device clocks data, parity, stop; 11th fall samples ACK
  // WAIT_IDLE | waiting for both lines to return high
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] INHIBIT   = 3'd1;
  localparam logic [2:0] REQ       = 3'd2;
  localparam logic [2:0] BITS      = 3'd3;
  localparam logic [2:0] WAIT_IDLE = 3'd4;

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [IW-1:0] INH_END = IW'(INHIBIT_CYCLES);
  localparam logic [TW-1:0] TO_END  = TW'(TIMEOUT_CYCLES);
  localparam logic [FW-1:0] FLT_END = FW'(FILTER_LEN - 1);

  logic [2:0]    state;
  logic [7:0]    data;
  logic          parity;
  logic [3:0]    n;
  logic [IW-1:0] inh_cnt;
  logic [TW-1:0] timer;
  logic          clk_oe_r;
  logic          dat_oe_r;

  logic [1:0]    clk_sync;
  logic [1:0]    dat_sync;
  logic [FW-1:0] clk_flt_cnt;
  logic [FW-1:0] dat_flt_cnt;
  logic          fclk;
  logic          fdat;
  logic          fclk_d;

  logic          fall;
  logic          timeout;
  logic          ack_fall;

  always_ff @(posedge clk7 or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk_in};
      dat_sync <= {dat_sync[0], ps2_din_in};
    end
  end

  // A filtered value only follows the synchronised input after FILTER_LEN equal samples.
  always_ff @(posedge clk7 or negedge rst_n) begin
    if (!rst_n) begin
      fclk        <= 1'b1;
      clk_flt_cnt <= '0;
    end else if (clk_sync[1] == fclk) begin
      clk_flt_cnt <= '0;
    end else if (clk_flt_cnt == FLT_END) begin
      fclk        <= clk_sync[1];
      clk_flt_cnt <= '0;
    end else begin
      clk_flt_cnt <= clk_flt_cnt + FW'(1);
    end
  end

  always_ff @(posedge clk7 or negedge rst_n) begin
    if (!rst_n) begin
      fdat        <= 1'b1;
      dat_flt_cnt <= '0;
    end else if (dat_sync[1] == fdat) begin
      dat_flt_cnt <= '0;
    end else if (dat_flt_cnt == FLT_END) begin
      fdat        <= dat_sync[1];
      dat_flt_cnt <= '0;
    end else begin
      dat_flt_cnt <= dat_flt_cnt + FW'(1);
    end
  end

  always_ff @(posedge clk7 or negedge rst_n) begin
    if (!rst_n) fclk_d <= 1'b1;
    else        fclk_d <= fclk;
  end

  // A fall needs fclk seen high first, so the host's own inhibit never counts as an edge.
  assign fall     = fclk_d & ~fclk;
  assign timeout  = ((state == BITS) || (state == WAIT_IDLE)) && (timer == TO_END);
  assign ack_fall = (state == BITS) && fall && (n == 4'd10);

  always_ff @(posedge clk7 or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      data     <= '0;
      parity   <= 1'b0;
      n        <= '0;
      inh_cnt  <= '0;
      timer    <= '0;
      clk_oe_r <= 1'b0;
      dat_oe_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          clk_oe_r <= 1'b0;
          dat_oe_r <= 1'b0;
          if (tx_valid) begin
            data     <= tx_data;
            parity   <= ~^tx_data;
            inh_cnt  <= IW'(1);
            clk_oe_r <= 1'b1;
            state    <= INHIBIT;
          end
        end
        INHIBIT: begin
          if (inh_cnt == INH_END) begin
            dat_oe_r <= 1'b1;
            state    <= REQ;
          end else begin
            inh_cnt <= inh_cnt + IW'(1);
          end
        end
        REQ: begin
          clk_oe_r <= 1'b0;
          n        <= '0;
          timer    <= '0;
          state    <= BITS;
        end
        BITS: begin
          if (timeout) begin
            dat_oe_r <= 1'b0;
            state    <= IDLE;
          end else if (fall) begin
            timer <= '0;
            n     <= n + 4'd1;
            case (n)
              4'd0, 4'd1, 4'd2, 4'd3,
              4'd4, 4'd5, 4'd6, 4'd7: dat_oe_r <= ~data[n[2:0]];
              4'd8:                   dat_oe_r <= ~parity;
              4'd9:                   dat_oe_r <= 1'b0;
              default: begin
                dat_oe_r <= 1'b0;
                state    <= fdat ? IDLE : WAIT_IDLE;
              end
            endcase
          end else begin
            timer <= timer + TW'(1);
          end
        end
        WAIT_IDLE: begin
          dat_oe_r <= 1'b0;
          if (timeout || (fclk && fdat)) begin
            state <= IDLE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: begin
          clk_oe_r <= 1'b0;
          dat_oe_r <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  assign ps2_clk_oe = clk_oe_r;
  assign ps2_dat_oe = dat_oe_r;
  assign tx_ready   = (state == IDLE);
  assign rx_inhibit = (state != IDLE);
  assign tx_error   = timeout | (ack_fall & fdat);
  assign tx_done    = ~timeout & (state == WAIT_IDLE) & fclk & fdat;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: open-drain bus with a behavioural PS/2 device model
// and a frame reference model built from the byte's bit order and odd parity.
module tb_ps2_host_tx;

  localparam int INH = 840;
  localparam int TO  = 2000;
  localparam int FL  = 4;
  localparam int LAT = 2 + FL + 1;  // raw line edge to the host acting on it

  logic       clk7 = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;
  logic       tx_ready, ps2_clk_oe, ps2_dat_oe, rx_inhibit, tx_done, tx_error;
  logic       ps2_clk_in, ps2_din_in;

  assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
  assign ps2_din_in = dev_dat & ~ps2_dat_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TO),
    .FILTER_LEN(FL)
  ) dut (
    .clk7(clk7),
    .rst_n(rst_n),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .ps2_clk_in(ps2_clk_in),
    .ps2_din_in(ps2_din_in),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_dat_oe(ps2_dat_oe),
    .rx_inhibit(rx_inhibit),
    .tx_done(tx_done),
    .tx_error(tx_error)
  );

  always #5 clk7 = ~clk7;

  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  int   err_cnt = 0;
  int   frame_cnt = 0;
  int   follow_bad = 0;
  logic clk_oe_q = 1'b0;
  logic pend = 1'b0;

  always @(negedge clk7) begin
    if (tx_done === 1'b1) done_cnt++;
    if (tx_error === 1'b1) err_cnt++;
    if (ps2_clk_oe === 1'b1 && clk_oe_q === 1'b0) frame_cnt++;
    if (pend && tx_ready !== 1'b1) follow_bad++;
    if ((tx_done === 1'b1 || tx_error === 1'b1) &&
        (tx_ready !== 1'b0 || (tx_done === 1'b1 && tx_error === 1'b1))) follow_bad++;
    pend = (tx_done === 1'b1 || tx_error === 1'b1);
    clk_oe_q = ps2_clk_oe;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [10:0] frame_model(input logic [7:0] d);
    logic [10:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = d[i];
    f[9]  = (($countones(d) % 2) == 0) ? 1'b1 : 1'b0;
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic host_send(input logic [7:0] d, input bit busy);
    int inh;
    @(negedge clk7);
    checks++;
    if (tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_ready got %b want 1", tx_ready);
    end
    tx_data = d;
    tx_valid = 1'b1;
    @(negedge clk7);
    tx_valid = 1'b0;
    tx_data = 8'($urandom);
    inh = 0;
    while (ps2_clk_oe === 1'b1 && ps2_dat_oe === 1'b0 && inh < INH + 100) begin
      inh++;
      tx_valid = busy && ((inh % 200) == 0);
      @(negedge clk7);
    end
    tx_valid = 1'b0;
    checks++;
    if (inh != INH) begin
      errors++;
      $display("FAIL inhibit_len got %0d want %0d", inh, INH);
    end
    checks++;
    if (ps2_clk_oe !== 1'b1 || ps2_dat_oe !== 1'b1) begin
      errors++;
      $display("FAIL req_phase got clk_oe=%b dat_oe=%b want 1 1", ps2_clk_oe, ps2_dat_oe);
    end
    @(negedge clk7);
    checks++;
    if ({ps2_clk_oe, ps2_dat_oe, rx_inhibit, tx_ready} !== 4'b0110) begin
      errors++;
      $display("FAIL bits_entry got clk_oe,dat_oe,rx_inhibit,tx_ready=%b want 0110",
               {ps2_clk_oe, ps2_dat_oe, rx_inhibit, tx_ready});
    end
  endtask

  // Device: clocks nfalls falls, samples the host's bit at each rise, ACKs before fall 11.
  task automatic dev_run(input int nfalls, input bit ack, input bit glitch, output logic [10:0] seen);
    int lo, hi;
    seen = '0;
    dev_dat = 1'b1;
    repeat (20) @(negedge clk7);
    seen[0] = ps2_din_in;
    for (int k = 1; k <= nfalls; k++) begin
      lo = $urandom_range(20, 40);
      hi = $urandom_range(20, 40);
      dev_clk = 1'b0;
      repeat (lo) @(negedge clk7);
      dev_clk = 1'b1;
      if (k <= 10) seen[k] = ps2_din_in;
      if (k == 11) dev_dat = 1'b1;
      if (glitch && (k == 3 || k == 7)) begin
        repeat (8) @(negedge clk7);
        dev_clk = 1'b0;
        repeat (2) @(negedge clk7);
        dev_clk = 1'b1;
        repeat (hi - 10) @(negedge clk7);
      end else if (k == 10 && ack) begin
        repeat (hi / 2) @(negedge clk7);
        dev_dat = 1'b0;
        repeat (hi - hi / 2) @(negedge clk7);
      end else begin
        repeat (hi) @(negedge clk7);
      end
    end
  endtask

  task automatic run_frame(input logic [7:0] d, input bit ack, input bit glitch, input bit busy,
                           output logic [10:0] seen);
    int d0, e0, f0;
    d0 = done_cnt;
    e0 = err_cnt;
    f0 = frame_cnt;
    host_send(d, busy);
    dev_run(11, ack, glitch, seen);
    repeat (30) @(negedge clk7);
    checks++;
    if (seen !== frame_model(d)) begin
      errors++;
      $display("FAIL frame_bits data=%h got %b want %b", d, seen, frame_model(d));
    end
    checks++;
    if (done_cnt - d0 != (ack ? 1 : 0)) begin
      errors++;
      $display("FAIL done_pulses data=%h got %0d want %0d", d, done_cnt - d0, ack ? 1 : 0);
    end
    checks++;
    if (err_cnt - e0 != (ack ? 0 : 1)) begin
      errors++;
      $display("FAIL error_pulses data=%h got %0d want %0d", d, err_cnt - e0, ack ? 0 : 1);
    end
    checks++;
    if (frame_cnt - f0 != 1) begin
      errors++;
      $display("FAIL frame_count got %0d want 1", frame_cnt - f0);
    end
    checks++;
    if ({ps2_clk_oe, ps2_dat_oe, tx_ready, rx_inhibit} !== 4'b0010) begin
      errors++;
      $display("FAIL idle_after_frame got clk_oe,dat_oe,tx_ready,rx_inhibit=%b want 0010",
               {ps2_clk_oe, ps2_dat_oe, tx_ready, rx_inhibit});
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk7);
    checks++;
    if ({ps2_clk_oe, ps2_dat_oe, tx_done, tx_error} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs got clk_oe,dat_oe,done,error=%b want 0000",
               {ps2_clk_oe, ps2_dat_oe, tx_done, tx_error});
    end
    checks++;
    if ({tx_ready, rx_inhibit} !== 2'b10) begin
      errors++;
      $display("FAIL reset_handshake got ready,inhibit=%b want 10", {tx_ready, rx_inhibit});
    end
    rst_n = 1'b1;
    repeat (10) @(negedge clk7);
    checks++;
    if ({tx_ready, rx_inhibit, ps2_clk_oe, ps2_dat_oe} !== 4'b1000) begin
      errors++;
      $display("FAIL post_reset_idle got %b want 1000",
               {tx_ready, rx_inhibit, ps2_clk_oe, ps2_dat_oe});
    end
  endtask

  task automatic test_frame_ed;
    logic [10:0] seen;
    run_frame(8'hED, 1'b1, 1'b0, 1'b0, seen);
    checks++;
    if (seen !== {1'b1, 1'b1, 8'hED, 1'b0}) begin
      errors++;
      $display("FAIL ed_literal got %b want %b", seen, {1'b1, 1'b1, 8'hED, 1'b0});
    end
  endtask

  task automatic test_frame_f4_busy;
    logic [10:0] seen;
    run_frame(8'hF4, 1'b1, 1'b0, 1'b1, seen);
    checks++;
    if (seen !== {1'b1, 1'b0, 8'hF4, 1'b0}) begin
      errors++;
      $display("FAIL f4_literal got %b want %b", seen, {1'b1, 1'b0, 8'hF4, 1'b0});
    end
  endtask

  task automatic test_nack;
    logic [10:0] seen;
    run_frame(8'($urandom), 1'b0, 1'b0, 1'b0, seen);
  endtask

  task automatic test_glitch;
    logic [10:0] seen;
    run_frame(8'($urandom), 1'b1, 1'b1, 1'b0, seen);
  endtask

  task automatic test_random;
    logic [10:0] seen;
    for (int i = 0; i < 4; i++) begin
      run_frame(8'($urandom), ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'b0, seen);
    end
  endtask

  task automatic test_timeout;
    logic [10:0] seen;
    int d0, e0, cnt;
    bit got;
    d0 = done_cnt;
    e0 = err_cnt;
    host_send(8'($urandom), 1'b0);
    dev_run(4, 1'b0, 1'b0, seen);
    dev_clk = 1'b0;
    cnt = 0;
    got = 1'b0;
    while (!got && cnt < TO + 200) begin
      @(posedge clk7);
      cnt++;
      @(negedge clk7);
      if (tx_error === 1'b1) got = 1'b1;
      if (cnt == 30) dev_clk = 1'b1;
    end
    checks++;
    if (!got || cnt != TO + LAT) begin
      errors++;
      $display("FAIL timeout_latency got %0d (seen=%0d) want %0d", cnt, got, TO + LAT);
    end
    @(negedge clk7);
    checks++;
    if ({ps2_clk_oe, ps2_dat_oe, tx_ready} !== 3'b001) begin
      errors++;
      $display("FAIL timeout_release got clk_oe,dat_oe,ready=%b want 001",
               {ps2_clk_oe, ps2_dat_oe, tx_ready});
    end
    repeat (10) @(negedge clk7);
    checks++;
    if (err_cnt - e0 != 1 || done_cnt - d0 != 0) begin
      errors++;
      $display("FAIL timeout_pulses got err=%0d done=%0d want 1 0", err_cnt - e0, done_cnt - d0);
    end
  endtask

  task automatic test_reset_mid;
    logic [10:0] seen;
    int d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    host_send(8'($urandom) & 8'hF7, 1'b0);
    dev_run(4, 1'b0, 1'b0, seen);
    checks++;
    if (ps2_dat_oe !== 1'b1) begin
      errors++;
      $display("FAIL mid_frame_drive got dat_oe=%b want 1", ps2_dat_oe);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ps2_clk_oe, ps2_dat_oe, rx_inhibit, tx_error} !== 4'b0000) begin
      errors++;
      $display("FAIL async_release got clk_oe,dat_oe,inhibit,error=%b want 0000",
               {ps2_clk_oe, ps2_dat_oe, rx_inhibit, tx_error});
    end
    repeat (3) @(negedge clk7);
    rst_n = 1'b1;
    @(negedge clk7);
    checks++;
    if (tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset got %b want 1", tx_ready);
    end
    repeat (50) @(negedge clk7);
    checks++;
    if (err_cnt - e0 != 0 || done_cnt - d0 != 0) begin
      errors++;
      $display("FAIL reset_silent got err=%0d done=%0d want 0 0", err_cnt - e0, done_cnt - d0);
    end
  endtask

  task automatic test_handshake;
    checks++;
    if (follow_bad != 0) begin
      errors++;
      $display("FAIL pulse_handshake got %0d violations want 0", follow_bad);
    end
  endtask

  initial begin
    test_reset;
    test_frame_ed;
    test_frame_f4_busy;
    test_nack;
    test_glitch;
    test_random;
    test_timeout;
    test_reset_mid;
    test_handshake;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
